wb_interconnect_rr_nxm: RTL and testbench
=========================================

Name: wb_interconnect_rr_NxM

Overview:
Parametrised Wishbone classic crossbar with N_INITIATORS initiators and N_TARGETS targets. Each target has its own round-robin arbiter with cycle locking. Unmapped addresses are answered by an internal error responder. Successor to the fixed-priority NxN interconnect; sits between initiator BFMs/cores and target peripherals.

Parameters:
WB_ADDR_WIDTH, 32, address width (AW)
WB_DATA_WIDTH, 32, data width (DW); sel width is DW/8
N_INITIATORS, 2, initiator port count (1..16)
N_TARGETS, 2, target port count (1..16)
T_ADR_MASK, {N_TARGETS{32'hF000_0000}}, packed per-target mask; target 0 in LSBs
T_ADR, {32'h1000_0000,32'h0000_0000}, packed per-target base; target 0 in LSBs
TIMEOUT_CYCLES, 64, response timeout; used only with WB_IC_TIMEOUT_EN

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
adr  in  N_INITIATORS*AW  initiator address, initiator i at slice i
dat_w  in  N_INITIATORS*DW  initiator write data
dat_r  out  N_INITIATORS*DW  read data to initiator
cyc  in  N_INITIATORS  bus cycle
stb  in  N_INITIATORS  strobe
we  in  N_INITIATORS  write enable
sel  in  N_INITIATORS*DW/8  byte selects
ack  out  N_INITIATORS  acknowledge to initiator
err  out  N_INITIATORS  error to initiator
tadr, tdat_w, tcyc, tstb, twe, tsel  out  N_TARGETS*{AW,DW,1,1,1,DW/8}  to targets
tdat_r  in  N_TARGETS*DW  target read data
tack, terr  in  N_TARGETS  target responses

Behaviour:
- Reset (reset==0 at posedge): all grants cleared. Round-robin pointers set to 0. All per-initiator FSMs go to IDLE. tcyc/tstb/ack/err = 0. dat_r/tadr/tdat_w/tsel/twe = 0.
- Decode: target = lowest index t with (adr & mask[t]) == (T_ADR[t] & mask[t]). If no target matches, the access is unmapped.
- Per-initiator FSM:
  - IDLE: on cyc&stb, decode. Mapped -> REQ. Unmapped -> ERR.
  - REQ: waits for grant from the target's arbiter.
  - ACTIVE: routed to the granted target.
  - ERR: err=1 for exactly one cycle, then IDLE if cyc==0, otherwise DECODE-again on the next stb.
- Arbiter per target:
  - Evaluated every cycle among initiators in REQ for that target.
  - Grant goes to the first requester at or after the rotating pointer, index wrapping N_INITIATORS-1 -> 0.
  - Grant is registered, so the first access of a cycle sees +1 cycle latency: stb at edge k, tstb visible after edge k+1.
  - Pointer becomes granted index+1 (mod N) when the grant is released.
- Lock: grant is held while the granted initiator keeps cyc=1, including across multiple stb beats, even if those address another target's range. Those beats still go to the locked target. Grant is released on the cycle cyc falls; that initiator returns to IDLE.
- ACTIVE routing is combinational:
  - tadr/tdat_w/tsel/twe/tstb/tcyc = initiator signals.
  - ack/err/dat_r = target tack/terr/tdat_r, gated by grant.
  - Ungranted initiators see ack=err=0 and dat_r=0.
- Simultaneous events:
  - Release and new request on the same target in the same cycle: new grant is computed on the next cycle (one idle cycle on that target).
  - Two initiators hitting different targets proceed concurrently with no stall.
- Target asserting tack and terr together: forwarded unchanged.
- Reset mid-transfer: grants dropped immediately. tcyc=0 on the next cycle. No ack is generated for the aborted beat.

Optional Feature:
WB_IC_TIMEOUT_EN
- Defined:
  - Per-target counter increments while tcyc&tstb&!tack&!terr. It is cleared on any response or when the grant drops.
  - On reaching TIMEOUT_CYCLES, the interconnect asserts err to the owning initiator for 1 cycle and forces tstb=0 for that cycle.
  - The counter then clears.
- Undefined: no counter is present; a hung target stalls its initiator indefinitely.

Test Plan:
- Single read: I0 reads 0x1000_0004, T1 acks 1 cycle after tstb with 0xDEAD_BEEF -> I0 dat_r=0xDEAD_BEEF, ack one cycle; T0 tcyc stays 0.
- Contention: I0 and I1 both raise cyc&stb to 0x0000_0010 in the same cycle after reset -> I0 granted first; I1 granted the cycle after I0 drops cyc; next contention grants I1 first.
- Lock: I0 holds cyc across 4 writes to 0x0000_0000..0x0000_000C while I1 requests T0 -> I1 receives no grant until I0 cyc=0; all 4 tack seen at T0.
- Unmapped: with mask 0xF000_0000, I1 accesses 0x2000_0000 -> err=1 for exactly one cycle one cycle after stb; no tcyc asserted.
- Concurrency/reset: I0->T0 and I1->T1 simultaneously -> both tcyc high in the same cycle. Pulse reset=0 mid-transfer -> all tcyc/ack/err 0 after the edge.
- With WB_IC_TIMEOUT_EN, TIMEOUT_CYCLES=8: target never acks -> initiator err asserted 8 cycles after the first tstb; without the macro, no err.

Source files
------------

// File: rtl/wb_interconnect_rr_nxm.sv
// wb_interconnect_rr_nxm
// Wishbone classic N-initiator x M-target crossbar. Every target owns a
// round-robin arbiter whose grant stays locked for the whole cyc of the
// initiator that won it. Unmapped addresses are answered locally with one
// err cycle.
// Optional build macro: WB_IC_TIMEOUT_EN adds a per-target response timeout
// that errors the owning initiator after TIMEOUT_CYCLES stalled cycles.
//
// Per-initiator FSM
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | no access pending; decodes the address on cyc&stb
//   S_REQ    | mapped access waiting for the decoded target's grant
//   S_ACTIVE | owns a target; all signals routed there until cyc drops
//   S_ERR    | unmapped access; err driven for this single cycle
module wb_interconnect_rr_nxm #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int N_INITIATORS  = 2,
    parameter int N_TARGETS     = 2,
    parameter logic [N_TARGETS*WB_ADDR_WIDTH-1:0] T_ADR_MASK = {N_TARGETS{32'hF000_0000}},
    parameter logic [N_TARGETS*WB_ADDR_WIDTH-1:0] T_ADR      = {32'h1000_0000, 32'h0000_0000},
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [N_INITIATORS*WB_ADDR_WIDTH-1:0]    adr,
    input  logic [N_INITIATORS*WB_DATA_WIDTH-1:0]    dat_w,
    output logic [N_INITIATORS*WB_DATA_WIDTH-1:0]    dat_r,
    input  logic [N_INITIATORS-1:0]                  cyc,
    input  logic [N_INITIATORS-1:0]                  stb,
    input  logic [N_INITIATORS-1:0]                  we,
    input  logic [N_INITIATORS*WB_DATA_WIDTH/8-1:0]  sel,
    output logic [N_INITIATORS-1:0]                  ack,
    output logic [N_INITIATORS-1:0]                  err,
    output logic [N_TARGETS*WB_ADDR_WIDTH-1:0]       tadr,
    output logic [N_TARGETS*WB_DATA_WIDTH-1:0]       tdat_w,
    output logic [N_TARGETS-1:0]                     tcyc,
    output logic [N_TARGETS-1:0]                     tstb,
    output logic [N_TARGETS-1:0]                     twe,
    output logic [N_TARGETS*WB_DATA_WIDTH/8-1:0]     tsel,
    input  logic [N_TARGETS*WB_DATA_WIDTH-1:0]       tdat_r,
    input  logic [N_TARGETS-1:0]                     tack,
    input  logic [N_TARGETS-1:0]                     terr
);

    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int NI = N_INITIATORS;
    localparam int NT = N_TARGETS;
    localparam int IW = (NI > 1) ? $clog2(NI) : 1;
    localparam int TW = (NT > 1) ? $clog2(NT) : 1;

    if (NI < 1 || NI > 16 || NT < 1 || NT > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("wb_interconnect_rr_nxm: port counts must be 1..16 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACTIVE, S_ERR} state_t;

    state_t          state_q   [NI];
    logic [TW-1:0]   tgt_q     [NI];
    logic [NT-1:0]   gnt_vld_q;
    logic [IW-1:0]   gnt_idx_q [NT];
    logic [IW-1:0]   ptr_q     [NT];

    logic [NI-1:0]   dec_hit;
    logic [TW-1:0]   dec_tgt   [NI];
    logic [NT-1:0]   arb_vld;
    logic [IW-1:0]   arb_idx   [NT];
    logic [NT-1:0]   to_hit;

    // Address decode: lowest-index matching target wins, so scan downwards.
    always_comb begin
        for (int i = 0; i < NI; i++) begin
            dec_hit[i] = 1'b0;
            dec_tgt[i] = '0;
            for (int t = NT - 1; t >= 0; t--) begin
                if ((adr[i*AW +: AW] & T_ADR_MASK[t*AW +: AW]) ==
                    (T_ADR[t*AW +: AW] & T_ADR_MASK[t*AW +: AW])) begin
                    dec_hit[i] = 1'b1;
                    dec_tgt[i] = TW'(t);
                end
            end
        end
    end

    // Round-robin pick for idle targets: first requester at or after the pointer.
    always_comb begin
        int j;
        j = 0;
        for (int t = 0; t < NT; t++) begin
            arb_vld[t] = 1'b0;
            arb_idx[t] = '0;
            if (!gnt_vld_q[t]) begin
                for (int k = NI - 1; k >= 0; k--) begin
                    j = int'(ptr_q[t]) + k;
                    if (j >= NI) j = j - NI;
                    if (state_q[j] == S_REQ && cyc[j] && tgt_q[j] == TW'(t)) begin
                        arb_vld[t] = 1'b1;
                        arb_idx[t] = IW'(j);
                    end
                end
            end
        end
    end

    // Initiator FSMs and per-target grant/pointer state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NI; i++) begin
                state_q[i] <= S_IDLE;
                tgt_q[i]   <= '0;
            end
            gnt_vld_q <= '0;
            for (int t = 0; t < NT; t++) begin
                gnt_idx_q[t] <= '0;
                ptr_q[t]     <= '0;
            end
        end else begin
            for (int t = 0; t < NT; t++) begin
                if (gnt_vld_q[t]) begin
                    // Release only; a waiting requester is picked on the next cycle.
                    if (!cyc[gnt_idx_q[t]]) begin
                        gnt_vld_q[t] <= 1'b0;
                        ptr_q[t]     <= (int'(gnt_idx_q[t]) == NI - 1) ? '0 : gnt_idx_q[t] + 1'b1;
                    end
                end else if (arb_vld[t]) begin
                    gnt_vld_q[t] <= 1'b1;
                    gnt_idx_q[t] <= arb_idx[t];
                end
            end
            for (int i = 0; i < NI; i++) begin
                case (state_q[i])
                    S_IDLE: begin
                        if (cyc[i] && stb[i]) begin
                            if (dec_hit[i]) begin
                                tgt_q[i]   <= dec_tgt[i];
                                state_q[i] <= S_REQ;
                            end else begin
                                state_q[i] <= S_ERR;
                            end
                        end
                    end
                    S_REQ: begin
                        if (!cyc[i])
                            state_q[i] <= S_IDLE;
                        else if (arb_vld[tgt_q[i]] && arb_idx[tgt_q[i]] == IW'(i))
                            state_q[i] <= S_ACTIVE;
                    end
                    S_ACTIVE: begin
                        if (!cyc[i]) state_q[i] <= S_IDLE;
                    end
                    S_ERR:   state_q[i] <= S_IDLE;
                    default: state_q[i] <= S_IDLE;
                endcase
            end
        end
    end

`ifdef WB_IC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] to_cnt_q [NT];

    // Timeout fires in the cycle the stall count reaches the limit.
    always_comb begin
        for (int t = 0; t < NT; t++)
            to_hit[t] = gnt_vld_q[t] && (to_cnt_q[t] == CW'(TIMEOUT_CYCLES));
    end

    // Count stalled strobe cycles; any response, a fired timeout or grant loss clears it.
    always_ff @(posedge clock) begin
        for (int t = 0; t < NT; t++) begin
            if (!reset || !gnt_vld_q[t] || tack[t] || terr[t] || to_hit[t])
                to_cnt_q[t] <= '0;
            else if (tcyc[t] && stb[gnt_idx_q[t]])
                to_cnt_q[t] <= to_cnt_q[t] + 1'b1;
        end
    end
`else
    assign to_hit = '0;
`endif

    // Combinational routing between each granted initiator and its target.
    always_comb begin
        int oi;
        oi     = 0;
        tadr   = '0;
        tdat_w = '0;
        tsel   = '0;
        twe    = '0;
        tcyc   = '0;
        tstb   = '0;
        ack    = '0;
        err    = '0;
        dat_r  = '0;
        for (int t = 0; t < NT; t++) begin
            if (gnt_vld_q[t]) begin
                oi = int'(gnt_idx_q[t]);
                tadr[t*AW +: AW]   = adr[oi*AW +: AW];
                tdat_w[t*DW +: DW] = dat_w[oi*DW +: DW];
                tsel[t*SW +: SW]   = sel[oi*SW +: SW];
                twe[t]             = we[oi];
                tcyc[t]            = cyc[oi];
                tstb[t]            = stb[oi] & ~to_hit[t];
                ack[oi]            = tack[t];
                err[oi]            = terr[t] | to_hit[t];
                dat_r[oi*DW +: DW] = tdat_r[t*DW +: DW];
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (state_q[i] == S_ERR) err[i] = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_interconnect_rr_nxm.sv
// Directed bench for wb_interconnect_rr_nxm (2 initiators, 2 targets,
// T0 at 0x0xxx_xxxx, T1 at 0x1xxx_xxxx, timeout limit 8 when enabled).
module tb_wb_interconnect_rr_nxm;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NI = 2;
    localparam int NT = 2;
    localparam int TO = 8;
`ifdef WB_IC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic [NI*AW-1:0]   adr;
    logic [NI*DW-1:0]   dat_w;
    logic [NI*DW-1:0]   dat_r;
    logic [NI-1:0]      cyc, stb, we, ack, err;
    logic [NI*DW/8-1:0] sel;
    logic [NT*AW-1:0]   tadr;
    logic [NT*DW-1:0]   tdat_w, tdat_r;
    logic [NT-1:0]      tcyc, tstb, twe, tack, terr;
    logic [NT*DW/8-1:0] tsel;

    int total = 0;
    int bad   = 0;
    int acks_seen;
    logic [31:0] beat_adr;
    logic exp_to;

    always #5 clock = ~clock;

    wb_interconnect_rr_nxm #(
        .WB_ADDR_WIDTH (AW),
        .WB_DATA_WIDTH (DW),
        .N_INITIATORS  (NI),
        .N_TARGETS     (NT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .adr   (adr),
        .dat_w (dat_w),
        .dat_r (dat_r),
        .cyc   (cyc),
        .stb   (stb),
        .we    (we),
        .sel   (sel),
        .ack   (ack),
        .err   (err),
        .tadr  (tadr),
        .tdat_w(tdat_w),
        .tcyc  (tcyc),
        .tstb  (tstb),
        .twe   (twe),
        .tsel  (tsel),
        .tdat_r(tdat_r),
        .tack  (tack),
        .terr  (terr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int i, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        cyc[i]             = c;
        stb[i]             = s;
        we[i]              = w;
        adr[i*AW +: AW]    = a;
        dat_w[i*DW +: DW]  = d;
        sel[i*4 +: 4]      = 4'hF;
    endtask

    task automatic nxt(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        adr = '0; dat_w = '0; cyc = '0; stb = '0; we = '0; sel = '0;
        tdat_r = '0; tack = '0; terr = '0;
        reset = 1'b0;
        nxt(3); #1;
        check("rst_tcyc",  tcyc,  0);
        check("rst_tstb",  tstb,  0);
        check("rst_ack",   ack,   0);
        check("rst_err",   err,   0);
        check("rst_dat_r", dat_r, 0);
        check("rst_tadr",  tadr,  0);
        reset = 1'b1;

        // single read I0 -> T1
        nxt(1); drive(0, 1, 1, 0, 32'h1000_0004, 0); #1;
        check("rd_no_tcyc_early", tcyc, 0);
        nxt(1); #1;
        check("rd_req_wait", tcyc, 0);
        nxt(1); #1;
        check("rd_tcyc", tcyc, 2'b10);
        check("rd_tstb", tstb, 2'b10);
        check("rd_tadr", tadr[63:32], 32'h1000_0004);
        check("rd_ack_pre", ack, 0);
        nxt(1); tack = 2'b10; tdat_r[63:32] = 32'hDEAD_BEEF; #1;
        check("rd_ack", ack, 2'b01);
        check("rd_dat", dat_r[31:0], 32'hDEAD_BEEF);
        check("rd_t0_idle", tcyc[0], 0);
        nxt(1); tack = '0; tdat_r = '0; drive(0, 0, 0, 0, 0, 0); #1;
        check("rd_ack_one", ack, 0);
        nxt(1);

        // contention on T0, pointer at 0 -> I0 first
        drive(0, 1, 1, 1, 32'h10, 32'hAAAA_0000);
        drive(1, 1, 1, 1, 32'h10, 32'hBBBB_0000);
        nxt(1); #1;
        check("ct_req", tcyc, 0);
        nxt(1); tack = 2'b01; #1;
        check("ct_g0_tcyc", tcyc, 2'b01);
        check("ct_g0_dat", tdat_w[31:0], 32'hAAAA_0000);
        check("ct_g0_ack", ack, 2'b01);
        nxt(1); tack = '0; drive(0, 0, 0, 0, 0, 0); #1;
        check("ct_drop", tcyc, 0);
        nxt(1); #1;
        check("ct_gap", tcyc, 0);
        nxt(1); tack = 2'b01; #1;
        check("ct_g1_tcyc", tcyc, 2'b01);
        check("ct_g1_dat", tdat_w[31:0], 32'hBBBB_0000);
        check("ct_g1_ack", ack, 2'b10);
        nxt(1); tack = '0; drive(1, 0, 0, 0, 0, 0);
        nxt(1);

        // I0 alone moves the T0 pointer to 1
        drive(0, 1, 1, 1, 32'h14, 32'h1111_0000);
        nxt(2); tack = 2'b01; #1;
        check("solo_tcyc", tcyc, 2'b01);
        nxt(1); tack = '0; drive(0, 0, 0, 0, 0, 0);
        nxt(1);

        // second contention -> I1 first
        drive(0, 1, 1, 1, 32'h10, 32'hAAAA_0000);
        drive(1, 1, 1, 1, 32'h10, 32'hBBBB_0000);
        nxt(2); tack = 2'b01; #1;
        check("ct2_first_i1", tdat_w[31:0], 32'hBBBB_0000);
        check("ct2_ack_i1", ack, 2'b10);
        nxt(1); tack = '0; drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        nxt(1);

        // lock: I0 holds T0 over 5 beats (last one in T1's range), I1 waits
        drive(0, 1, 1, 1, 32'h0, 32'hC0DE_0000);
        drive(1, 1, 1, 1, 32'h20, 32'h5555_0000);
        nxt(2);
        acks_seen = 0;
        for (int b = 0; b < 5; b++) begin
            beat_adr = (b < 4) ? 32'(4 * b) : 32'h1000_0010;
            drive(0, 1, 1, 1, beat_adr, 32'hC0DE_0000 + 32'(b));
            tack = 2'b01;
            #1;
            check($sformatf("lk_tadr%0d", b), tadr[31:0], beat_adr);
            check($sformatf("lk_ack%0d", b), ack, 2'b01);
            check($sformatf("lk_t1_idle%0d", b), tcyc[1], 0);
            if (tstb[0] && tack[0]) acks_seen++;
            nxt(1);
        end
        tack = '0; drive(0, 1, 0, 1, 0, 32'hC0DE_0004); #1;
        check("lk_acks", acks_seen, 5);
        nxt(1); #1;
        check("lk_hold_tcyc", tcyc, 2'b01);
        check("lk_hold_owner", tdat_w[31:0], 32'hC0DE_0004);
        drive(0, 0, 0, 0, 0, 0);
        nxt(1); #1;
        check("lk_gap", tcyc, 0);
        nxt(1); #1;
        check("lk_i1_tcyc", tcyc, 2'b01);
        check("lk_i1_dat", tdat_w[31:0], 32'h5555_0000);
        drive(1, 0, 0, 0, 0, 0);
        nxt(1);

        // unmapped access from I1
        drive(1, 1, 1, 0, 32'h2000_0000, 0); #1;
        check("um_err_early", err, 0);
        nxt(1); #1;
        check("um_err", err, 2'b10);
        check("um_tcyc", tcyc, 0);
        drive(1, 0, 0, 0, 0, 0);
        nxt(1); #1;
        check("um_err_once", err, 0);
        check("um_tcyc_after", tcyc, 0);

        // concurrent I0->T0, I1->T1, then reset mid-transfer
        drive(0, 1, 1, 0, 32'h0000_0040, 0);
        drive(1, 1, 1, 0, 32'h1000_0040, 0);
        nxt(2); #1;
        check("cc_both", tcyc, 2'b11);
        check("cc_tadr", tadr, 64'h1000_0040_0000_0040);
        reset = 1'b0;
        nxt(1); tack = 2'b11; #1;
        check("rs_tcyc", tcyc, 0);
        check("rs_ack", ack, 0);
        check("rs_err", err, 0);
        tack = '0; drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        nxt(1);

        // hung target: timeout err 8 cycles after the first tstb when enabled
        drive(0, 1, 1, 0, 32'h100, 0);
        nxt(2);
        for (int m = 0; m <= TO; m++) begin
            #1;
            exp_to = (m == TO) && TO_EN;
            check($sformatf("to_err%0d", m), err[0], exp_to);
            check($sformatf("to_tstb%0d", m), tstb[0], !exp_to);
            if (m < TO) nxt(1);
        end
        drive(0, 0, 0, 0, 0, 0);
        nxt(1); #1;
        check("to_after", err, 0);
        nxt(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
